// File: rtl/cpu_types_pkg.sv
// Shared pipeline types: word/register widths, memory-stage FSM states and
// the MEM/WB register bank command encoding.
package cpu_types_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [REG_W-1:0]  regbits_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HALT = 2'd2
    } memstate_t;

    // WB_HALT keeps the retired HALT visible and blocks any further register write.
    typedef enum logic [1:0] {
        WB_HOLD   = 2'd0,
        WB_LOAD   = 2'd1,
        WB_BUBBLE = 2'd2,
        WB_HALT   = 2'd3
    } wb_cmd_t;

    function automatic logic [DATA_W-1:0] lui_data(input logic [DATA_W-1:0] instr);
        return {instr[15:0], 16'h0000};
    endfunction

endpackage

// File: rtl/mem_stage_ctrl_wb.sv
// MEM/WB boundary register bank: load, bubble, hold and halt-hold commands.
// Bubbles clear only the control bits; data fields keep their last values.
module mem_stage_ctrl_wb
    import cpu_types_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  wb_cmd_t           i_cmd,
    input  logic              i_cap_load,
    input  logic              i_memtoreg,
    input  logic              i_wen,
    input  logic              i_luiflag,
    input  logic              i_cuhalt,
    input  logic [4:0]        i_wsel,
    input  logic [WORD_W-1:0] i_output_port,
    input  logic [WORD_W-1:0] i_dmemload,
    input  logic [WORD_W-1:0] i_instr,
    output logic              o_memtoreg,
    output logic              o_wen,
    output logic              o_luiflag,
    output logic              o_cuhalt,
    output logic [4:0]        o_wsel,
    output logic [WORD_W-1:0] o_output_port,
    output logic [WORD_W-1:0] o_dmemload,
    output logic [WORD_W-1:0] o_instr,
    output logic [WORD_W-1:0] o_luidata
);

    logic              r_memtoreg;
    logic              r_wen;
    logic              r_luiflag;
    logic              r_cuhalt;
    logic [4:0]        r_wsel;
    logic [WORD_W-1:0] r_output_port;
    logic [WORD_W-1:0] r_dmemload;
    logic [WORD_W-1:0] r_instr;
    logic [WORD_W-1:0] r_luidata;
    logic [WORD_W-1:0] w_luidata;

    assign w_luidata = {i_instr[15:0], {(WORD_W-16){1'b0}}};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_memtoreg    <= 1'b0;
            r_wen         <= 1'b0;
            r_luiflag     <= 1'b0;
            r_cuhalt      <= 1'b0;
            r_wsel        <= '0;
            r_output_port <= '0;
            r_dmemload    <= '0;
            r_instr       <= '0;
            r_luidata     <= '0;
        end else begin
            case (i_cmd)
                WB_LOAD: begin
                    r_memtoreg    <= i_memtoreg;
                    r_wen         <= i_wen;
                    r_luiflag     <= i_luiflag;
                    r_cuhalt      <= i_cuhalt;
                    r_wsel        <= i_wsel;
                    r_output_port <= i_output_port;
                    r_instr       <= i_instr;
                    r_luidata     <= w_luidata;
                    // Load data is only meaningful in the cycle the load completes.
                    if (i_cap_load) begin
                        r_dmemload <= i_dmemload;
                    end
                end
                WB_BUBBLE: begin
                    r_memtoreg <= 1'b0;
                    r_wen      <= 1'b0;
                    r_luiflag  <= 1'b0;
                    r_cuhalt   <= 1'b0;
                end
                WB_HALT: begin
                    r_wen    <= 1'b0;
                    r_cuhalt <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign o_memtoreg    = r_memtoreg;
    assign o_wen         = r_wen;
    assign o_luiflag     = r_luiflag;
    assign o_cuhalt      = r_cuhalt;
    assign o_wsel        = r_wsel;
    assign o_output_port = r_output_port;
    assign o_dmemload    = r_dmemload;
    assign o_instr       = r_instr;
    assign o_luidata     = r_luidata;

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory stage: issues dmem load/store requests with a dhit handshake, stalls
// upstream while a request is outstanding, and drains the pipe on HALT.
module mem_stage_ctrl
    import cpu_types_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              memValid,
    input  logic              memREN,
    input  logic              memWENd,
    input  logic              memMemToReg,
    input  logic              memWEN,
    input  logic              memLUIflag,
    input  logic              memcuHALT,
    input  logic [4:0]        memwsel,
    input  logic [WORD_W-1:0] memOutput_Port,
    input  logic [WORD_W-1:0] memrdat2,
    input  logic [WORD_W-1:0] meminstr,
    input  logic              dhit,
    input  logic [WORD_W-1:0] dmemload,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [WORD_W-1:0] dmemaddr,
    output logic [WORD_W-1:0] dmemstore,
    output logic              memStall,
    output logic              wbMemToReg,
    output logic              wbWEN,
    output logic              wbLUIflag,
    output logic              wbcuHALT,
    output logic [4:0]        wbwsel,
    output logic [WORD_W-1:0] wbOutput_Port,
    output logic [WORD_W-1:0] wbdmemload,
    output logic [WORD_W-1:0] wbinstr,
    output logic [WORD_W-1:0] wbLUIdata,
    output logic [CNT_W-1:0]  stallCount,
    output memstate_t         o_state
);

    memstate_t        r_state;
    logic [CNT_W-1:0] r_stall_cnt;
    wb_cmd_t          w_wb_cmd;
    logic             w_halt_in;
    logic             w_memop;
    logic             w_req_window;
    logic             w_ren;
    logic             w_wen;
    logic             w_stall;
    logic             w_cap_load;

    // A HALT in the slot outranks any memory op encoded alongside it.
    assign w_halt_in    = memValid & memcuHALT;
    assign w_memop      = memValid & ~memcuHALT & (memREN | memWENd);
    assign w_req_window = (r_state == IDLE) || (r_state == WAIT);

    // Load wins over an (illegal) simultaneous store.
    assign w_ren = w_req_window & memValid & ~memcuHALT & memREN;
    assign w_wen = w_req_window & memValid & ~memcuHALT & memWENd & ~memREN;

    assign w_stall    = (r_state == HALT) | (w_req_window & w_memop & ~dhit);
    assign w_cap_load = w_ren & dhit;

    always_comb begin
        w_wb_cmd = WB_BUBBLE;
        case (r_state)
            IDLE: begin
                if (w_halt_in) begin
                    w_wb_cmd = WB_LOAD;
                end else if (w_memop) begin
                    w_wb_cmd = dhit ? WB_LOAD : WB_BUBBLE;
                end else if (memValid) begin
                    w_wb_cmd = WB_LOAD;
                end else begin
                    w_wb_cmd = WB_BUBBLE;
                end
            end
            WAIT: begin
                w_wb_cmd = dhit ? WB_LOAD : WB_BUBBLE;
            end
            HALT: begin
                w_wb_cmd = WB_HALT;
            end
            default: begin
                w_wb_cmd = WB_BUBBLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_halt_in) begin
                        r_state <= HALT;
                    end else if (w_memop && !dhit) begin
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (dhit) begin
                        r_state <= IDLE;
                    end
                end
                HALT: begin
                    r_state <= HALT;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    mem_stage_ctrl_wb #(
        .WORD_W (WORD_W)
    ) u_wb (
        .i_clk         (CLK),
        .i_rst         (RST),
        .i_cmd         (w_wb_cmd),
        .i_cap_load    (w_cap_load),
        .i_memtoreg    (memMemToReg),
        .i_wen         (memWEN),
        .i_luiflag     (memLUIflag),
        .i_cuhalt      (memcuHALT),
        .i_wsel        (memwsel),
        .i_output_port (memOutput_Port),
        .i_dmemload    (dmemload),
        .i_instr       (meminstr),
        .o_memtoreg    (wbMemToReg),
        .o_wen         (wbWEN),
        .o_luiflag     (wbLUIflag),
        .o_cuhalt      (wbcuHALT),
        .o_wsel        (wbwsel),
        .o_output_port (wbOutput_Port),
        .o_dmemload    (wbdmemload),
        .o_instr       (wbinstr),
        .o_luidata     (wbLUIdata)
    );

    assign dmemREN    = w_ren;
    assign dmemWEN    = w_wen;
    assign dmemaddr   = memOutput_Port;
    assign dmemstore  = memrdat2;
    assign memStall   = w_stall;
    assign stallCount = r_stall_cnt;
    assign o_state    = r_state;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: expected writebacks are queued when an
// instruction is driven and checked after the edge that retires it.
module tb_mem_stage_ctrl;
    import cpu_types_pkg::*;

    localparam int W  = 32;
    localparam int CW = 16;

    logic          CLK = 1'b0;
    logic          RST;
    logic          memValid, memREN, memWENd, memMemToReg, memWEN, memLUIflag, memcuHALT;
    logic [4:0]    memwsel;
    logic [W-1:0]  memOutput_Port, memrdat2, meminstr;
    logic          dhit;
    logic [W-1:0]  dmemload;
    logic          dmemREN, dmemWEN, memStall;
    logic [W-1:0]  dmemaddr, dmemstore;
    logic          wbMemToReg, wbWEN, wbLUIflag, wbcuHALT;
    logic [4:0]    wbwsel;
    logic [W-1:0]  wbOutput_Port, wbdmemload, wbinstr, wbLUIdata;
    logic [CW-1:0] stallCount;
    memstate_t     o_state;

    typedef struct packed {
        logic         memtoreg;
        logic         wen;
        logic         luiflag;
        logic         cuhalt;
        logic [4:0]   wsel;
        logic [W-1:0] outp;
        logic [W-1:0] dload;
        logic [W-1:0] instr;
        logic [W-1:0] lui;
    } wb_t;

    wb_t          exp_q[$];
    int           total = 0;
    int           bad   = 0;
    logic [W-1:0] last_load = '0;

    always #5 CLK = ~CLK;

    mem_stage_ctrl #(.WORD_W(W), .CNT_W(CW)) dut (
        .CLK(CLK), .RST(RST),
        .memValid(memValid), .memREN(memREN), .memWENd(memWENd),
        .memMemToReg(memMemToReg), .memWEN(memWEN), .memLUIflag(memLUIflag),
        .memcuHALT(memcuHALT), .memwsel(memwsel), .memOutput_Port(memOutput_Port),
        .memrdat2(memrdat2), .meminstr(meminstr), .dhit(dhit), .dmemload(dmemload),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .memStall(memStall), .wbMemToReg(wbMemToReg), .wbWEN(wbWEN),
        .wbLUIflag(wbLUIflag), .wbcuHALT(wbcuHALT), .wbwsel(wbwsel),
        .wbOutput_Port(wbOutput_Port), .wbdmemload(wbdmemload), .wbinstr(wbinstr),
        .wbLUIdata(wbLUIdata), .stallCount(stallCount), .o_state(o_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        memValid = 1'b0; memREN = 1'b0; memWENd = 1'b0; memMemToReg = 1'b0;
        memWEN = 1'b0; memLUIflag = 1'b0; memcuHALT = 1'b0; memwsel = '0;
        memOutput_Port = '0; memrdat2 = '0; meminstr = '0; dhit = 1'b0; dmemload = '0;
    endtask

    // Expected writeback for the instruction currently on the inputs.
    task automatic push_exp(input logic captured);
        wb_t e;
        e.memtoreg = memMemToReg;
        e.wen      = memWEN;
        e.luiflag  = memLUIflag;
        e.cuhalt   = memcuHALT;
        e.wsel     = memwsel;
        e.outp     = memOutput_Port;
        e.instr    = meminstr;
        e.lui      = {meminstr[15:0], 16'h0000};
        if (captured) last_load = dmemload;
        e.dload    = last_load;
        exp_q.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        wb_t e;
        chk({tag, "_qnonempty"}, 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        chk({tag, "_memtoreg"}, 32'(wbMemToReg), 32'(e.memtoreg));
        chk({tag, "_wen"},      32'(wbWEN),      32'(e.wen));
        chk({tag, "_luiflag"},  32'(wbLUIflag),  32'(e.luiflag));
        chk({tag, "_cuhalt"},   32'(wbcuHALT),   32'(e.cuhalt));
        chk({tag, "_wsel"},     32'(wbwsel),     32'(e.wsel));
        chk({tag, "_outp"},     wbOutput_Port,   e.outp);
        chk({tag, "_dload"},    wbdmemload,      e.dload);
        chk({tag, "_instr"},    wbinstr,         e.instr);
        chk({tag, "_lui"},      wbLUIdata,       e.lui);
    endtask

    task automatic check_bubble(input string tag);
        chk({tag, "_wen"},      32'(wbWEN),      32'd0);
        chk({tag, "_memtoreg"}, 32'(wbMemToReg), 32'd0);
        chk({tag, "_luiflag"},  32'(wbLUIflag),  32'd0);
        chk({tag, "_cuhalt"},   32'(wbcuHALT),   32'd0);
    endtask

    initial begin
        RST = 1'b1;
        clear_inputs();
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;

        // Reset state
        chk("rst_state", 32'(o_state), 32'(IDLE));
        chk("rst_stallcnt", 32'(stallCount), 32'd0);
        chk("rst_ren", 32'(dmemREN), 32'd0);
        chk("rst_stall", 32'(memStall), 32'd0);
        chk("rst_wsel", 32'(wbwsel), 32'd0);
        chk("rst_outp", wbOutput_Port, 32'd0);
        check_bubble("rst");

        // ALU op, single-cycle writeback
        memValid = 1'b1; memWEN = 1'b1; memwsel = 5'd5;
        memOutput_Port = 32'h0000_1234; meminstr = 32'($urandom());
        settle();
        chk("alu_stall", 32'(memStall), 32'd0);
        chk("alu_ren", 32'(dmemREN), 32'd0);
        chk("alu_wen", 32'(dmemWEN), 32'd0);
        push_exp(1'b0);
        tick();
        pop_check("alu");

        // Empty slot: bubble, data held
        clear_inputs();
        tick();
        check_bubble("bub");
        chk("bub_wsel_held", 32'(wbwsel), 32'd5);

        // Load with three wait cycles
        clear_inputs();
        memValid = 1'b1; memREN = 1'b1; memMemToReg = 1'b1; memWEN = 1'b1;
        memwsel = 5'd7; memOutput_Port = 32'h0000_0100; meminstr = 32'($urandom());
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("ld_ren", 32'(dmemREN), 32'd1);
            chk("ld_stall", 32'(memStall), 32'd1);
            chk("ld_addr", dmemaddr, 32'h0000_0100);
            chk("ld_wen", 32'(dmemWEN), 32'd0);
            tick();
            check_bubble("ld_wait");
            chk("ld_state", 32'(o_state), 32'(WAIT));
        end
        dhit = 1'b1; dmemload = 32'hDEAD_BEEF;
        settle();
        chk("ld_hit_stall", 32'(memStall), 32'd0);
        chk("ld_hit_ren", 32'(dmemREN), 32'd1);
        push_exp(1'b1);
        tick();
        pop_check("ld");
        chk("ld_state_idle", 32'(o_state), 32'(IDLE));
        chk("ld_stallcnt", 32'(stallCount), 32'd3);

        // Zero-wait store
        clear_inputs();
        memValid = 1'b1; memWENd = 1'b1; memOutput_Port = 32'h0000_0200;
        memrdat2 = 32'h0000_CAFE; memwsel = 5'd9; meminstr = 32'($urandom()); dhit = 1'b1;
        settle();
        chk("st_wen", 32'(dmemWEN), 32'd1);
        chk("st_ren", 32'(dmemREN), 32'd0);
        chk("st_addr", dmemaddr, 32'h0000_0200);
        chk("st_data", dmemstore, 32'h0000_CAFE);
        chk("st_stall", 32'(memStall), 32'd0);
        push_exp(1'b0);
        tick();
        pop_check("st");
        chk("st_state", 32'(o_state), 32'(IDLE));
        chk("st_stallcnt", 32'(stallCount), 32'd3);

        // Load and store both set: load wins
        clear_inputs();
        memValid = 1'b1; memREN = 1'b1; memWENd = 1'b1; memMemToReg = 1'b1; memWEN = 1'b1;
        memwsel = 5'd12; memOutput_Port = 32'($urandom()); meminstr = 32'($urandom());
        dhit = 1'b1; dmemload = 32'($urandom());
        settle();
        chk("ill_ren", 32'(dmemREN), 32'd1);
        chk("ill_wen", 32'(dmemWEN), 32'd0);
        push_exp(1'b1);
        tick();
        pop_check("ill");

        // LUI
        clear_inputs();
        memValid = 1'b1; memWEN = 1'b1; memLUIflag = 1'b1; memwsel = 5'd1;
        meminstr = 32'h3C01_ABCD; memOutput_Port = 32'($urandom_range(0, 65535));
        settle();
        push_exp(1'b0);
        tick();
        pop_check("lui");
        chk("lui_data", wbLUIdata, 32'hABCD_0000);
        chk("lui_flag", 32'(wbLUIflag), 32'd1);

        // Store with two wait cycles, then HALT
        clear_inputs();
        memValid = 1'b1; memWENd = 1'b1; memOutput_Port = 32'h0000_0300;
        memrdat2 = 32'h0000_0077; memwsel = 5'd2; meminstr = 32'($urandom());
        settle();
        chk("pst_stall0", 32'(memStall), 32'd1);
        chk("pst_wen0", 32'(dmemWEN), 32'd1);
        tick();
        chk("pst_state", 32'(o_state), 32'(WAIT));
        settle();
        chk("pst_wen1", 32'(dmemWEN), 32'd1);
        chk("pst_addr1", dmemaddr, 32'h0000_0300);
        tick();
        dhit = 1'b1;
        settle();
        chk("pst_hit_stall", 32'(memStall), 32'd0);
        push_exp(1'b0);
        tick();
        pop_check("pst");
        chk("pst_stallcnt", 32'(stallCount), 32'd5);

        clear_inputs();
        memValid = 1'b1; memcuHALT = 1'b1; memREN = 1'b1;
        meminstr = 32'hFC00_0000 | 32'($urandom_range(0, 1023));
        dmemload = 32'($urandom());
        settle();
        chk("halt_ren", 32'(dmemREN), 32'd0);
        chk("halt_stall", 32'(memStall), 32'd0);
        push_exp(1'b0);
        tick();
        pop_check("halt");
        chk("halt_state", 32'(o_state), 32'(HALT));

        memcuHALT = 1'b0;
        for (int i = 0; i < 12; i++) begin
            memREN  = ((i % 2) == 0);
            memWENd = ((i % 2) == 1);
            dhit    = 1'($urandom_range(0, 1));
            settle();
            chk("hlt_ren", 32'(dmemREN), 32'd0);
            chk("hlt_wen", 32'(dmemWEN), 32'd0);
            chk("hlt_stall", 32'(memStall), 32'd1);
            tick();
            chk("hlt_cuhalt", 32'(wbcuHALT), 32'd1);
            chk("hlt_wbwen", 32'(wbWEN), 32'd0);
            chk("hlt_state", 32'(o_state), 32'(HALT));
        end
        chk("hlt_stallcnt", 32'(stallCount), 32'd17);

        // Leave HALT, then reset while a load is pending
        clear_inputs();
        RST = 1'b1;
        last_load = '0;
        tick();
        RST = 1'b0;
        chk("rst2_state", 32'(o_state), 32'(IDLE));
        chk("rst2_stallcnt", 32'(stallCount), 32'd0);

        memValid = 1'b1; memWEN = 1'b1; memwsel = 5'd3;
        memOutput_Port = 32'h0000_A5A5; meminstr = 32'h1234_5678;
        settle();
        push_exp(1'b0);
        tick();
        pop_check("alu2");

        clear_inputs();
        memValid = 1'b1; memREN = 1'b1; memMemToReg = 1'b1; memWEN = 1'b1;
        memwsel = 5'd4; memOutput_Port = 32'h0000_0400; meminstr = 32'($urandom());
        settle();
        tick();
        chk("rw_state_wait", 32'(o_state), 32'(WAIT));
        chk("rw_stallcnt1", 32'(stallCount), 32'd1);
        RST = 1'b1;
        settle();
        tick();
        chk("rw_state", 32'(o_state), 32'(IDLE));
        chk("rw_stallcnt", 32'(stallCount), 32'd0);
        check_bubble("rw");
        chk("rw_wsel", 32'(wbwsel), 32'd0);
        chk("rw_outp", wbOutput_Port, 32'd0);
        chk("rw_dload", wbdmemload, 32'd0);
        chk("rw_instr", wbinstr, 32'd0);
        chk("rw_lui", wbLUIdata, 32'd0);
        RST = 1'b0;
        clear_inputs();
        settle();
        chk("rw_ren", 32'(dmemREN), 32'd0);
        chk("rw_stall", 32'(memStall), 32'd0);

        chk("q_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Memory stage of the 5-stage pipeline. Takes the EX/MEM-latched instruction, issues data-memory load/store requests with a dhit handshake, and stalls upstream while a request is outstanding.
- Registers the results into the MEM/WB boundary (wb* outputs) consumed by the writeback stage.
- Owns the halt-drain FSM: the pipeline is quiescent once HALT retires.

Parameters:
- WORD_W, 32, datapath word width
- CNT_W, 16, width of the saturating stall-cycle counter

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  synchronous, active-high reset
- memValid  in  1  EX/MEM slot holds a real instruction (0 = bubble)
- memREN  in  1  instruction is a load
- memWENd  in  1  instruction is a store
- memMemToReg  in  1  writeback selects load data
- memWEN  in  1  register-file write enable
- memLUIflag  in  1  instruction is LUI
- memcuHALT  in  1  instruction is HALT
- memwsel  in  5  destination register
- memOutput_Port  in  WORD_W  ALU result / memory address
- memrdat2  in  WORD_W  store data
- meminstr  in  WORD_W  instruction word
- dhit  in  1  data memory access complete this cycle
- dmemload  in  WORD_W  load data, valid with dhit
- dmemREN  out  1  data read request
- dmemWEN  out  1  data write request
- dmemaddr  out  WORD_W  request address
- dmemstore  out  WORD_W  store data
- memStall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM this cycle
- wbMemToReg, wbWEN, wbLUIflag, wbcuHALT  out  1 each  registered MEM/WB controls
- wbwsel  out  5  registered destination
- wbOutput_Port, wbdmemload, wbinstr, wbLUIdata  out  WORD_W  registered data
- stallCount  out  CNT_W  saturating count of memStall cycles since reset

Behaviour:
- Clocking: one clock, CLK. RST is synchronous and active-high.
- Reset: FSM=IDLE, all wb* outputs and stallCount are 0. Request and stall outputs are 0 because they decode from IDLE. Reset asserted mid-access (WAIT) abandons the request: dmemREN/WEN drop the following cycle and no writeback is produced.
- Definition: memop = memValid & (memREN | memWENd).
- Requests are combinational:
  - dmemREN = memREN & memValid in IDLE or WAIT, else 0; dmemWEN likewise with memWENd.
  - dmemaddr = memOutput_Port; dmemstore = memrdat2.
  - memREN & memWENd both set is illegal; the load takes priority and the store is suppressed.
- memStall = memop & ~dhit in IDLE or WAIT; memStall = 1 in HALT.
- FSM states: IDLE, WAIT, HALT.
  - IDLE:
    - memValid & memcuHALT -> HALT; the HALT is latched to WB with wbcuHALT=1.
    - memop & dhit -> stay in IDLE; latch to WB the same cycle (zero-wait access, 1-cycle stage latency).
    - memop & ~dhit -> WAIT; latch a bubble to WB.
    - Non-memory valid instruction -> latch to WB.
  - WAIT: hold the request stable. On dhit -> latch to WB, go to IDLE. Otherwise latch a bubble.
  - HALT: absorbing until RST. No dmem requests. The WB register keeps wbcuHALT=1 and wbWEN=0 after the HALT writeback cycle.
- Latch to WB: copy mem* fields into wb*.
  - wbdmemload = dmemload, captured only on dhit of a load.
  - wbLUIdata = {meminstr[15:0], 16'h0}.
- Bubble: wbWEN=0, wbMemToReg=0, wbLUIflag=0, wbcuHALT=0. Data fields are don't-care and are held.
- memValid=0 in IDLE latches a bubble.
- stallCount increments on every memStall=1 cycle, saturating at all-ones.
- memcuHALT together with memREN/WENd: the HALT wins and no request is issued.

Decomposition:
- Add to cpu_types_pkg: word_t (already present), regbits_t (5 bits), and the enum memstate_t {IDLE, WAIT, HALT}.
- Optional sub-module: mem_wb_reg, holding the WB register bank with load/bubble/hold controls. The FSM and request logic stay in mem_stage_ctrl.
- Expose ports through the existing mem_wb_if memwb modport signal names where they coincide.

Test Plan:
- Reset then ALU op (memValid=1, memWEN=1, wsel=5, Output_Port=0x1234): next edge wbWEN=1, wbwsel=5, wbOutput_Port=0x1234; memStall never 1.
- Load, addr 0x100, dhit after 3 cycles with dmemload=0xDEADBEEF: dmemREN=1 and memStall=1 for 3 cycles; wb bubbles during the wait; on the hit edge wbdmemload=0xDEADBEEF, wbMemToReg=1; stallCount=3.
- Store with dhit the same cycle (addr 0x200, rdat2=0xCAFE): dmemWEN=1, dmemaddr=0x200, dmemstore=0xCAFE, memStall=0, FSM stays in IDLE.
- LUI, meminstr[15:0]=0xABCD: wbLUIdata=0xABCD0000, wbLUIflag=1.
- HALT after a pending store completes: wbcuHALT=1; memStall held at 1; dmemREN/WEN stay 0 for 10+ cycles even when memValid=1 with memREN=1.
- RST asserted in WAIT (load pending, no dhit): next cycle dmemREN=0, all wb* outputs 0, stallCount=0, FSM=IDLE.
